fa_share_ctrl: RTL and testbench

Sequencer and arbiter sharing a single full-adder bit slice between two requesters. Each request supplies two WIDTH-bit operands. The block adds them bit-serially, LSB first, by driving one full-adder slice (sum = a^b^ci, co = a&b | (a^b)&ci) with a carry flop, then returns a WIDTH-bit sum and carry-out. It lets stopwatch-side logic (e.g. time-accumulate and lap-offset paths) do arithmetic through one adder slice instead of two ripple adders.

---
 rtl/fa_share_ctrl.sv | 118 +++++++++++
 tb/tb_fa_share_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_share_ctrl.sv
// rtl/fa_share_ctrl.sv - two-requester arbiter driving one shared full-adder slice bit-serially
module fa_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             done,
    output logic             done_id
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sel_id, last_id;

    logic             any_req, pick_id, last_bit, s_bit, c_nxt;
    logic             gnt0_nxt, gnt1_nxt, busy_nxt, done_nxt;

    // Round-robin only matters on contention; a lone requester always wins.
    assign any_req  = req0 | req1;
    assign pick_id  = (req0 & req1) ? ~last_id : req1;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt    = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ADD;
            ADD:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0_nxt = 1'b0;
        gnt1_nxt = 1'b0;
        done_nxt = 1'b0;
        busy_nxt = (state_nxt != IDLE);
        if (state == IDLE && any_req) begin
            gnt0_nxt = ~pick_id;
            gnt1_nxt = pick_id;
        end
        if (state == ADD && last_bit) done_nxt = 1'b1;
    end

    // Outputs are registered from the decoded next values; datapath advances alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            co      <= 1'b0;
            done_id <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sel_id  <= 1'b0;
            last_id <= 1'b1;
        end else begin
            gnt0 <= gnt0_nxt;
            gnt1 <= gnt1_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_sh    <= pick_id ? a1 : a0;
                        b_sh    <= pick_id ? b1 : b0;
                        res_sh  <= '0;
                        carry   <= 1'b0;
                        cnt     <= '0;
                        sel_id  <= pick_id;
                        last_id <= pick_id;
                    end
                end
                ADD: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= {s_bit, res_sh[WIDTH-1:1]};
                    carry  <= c_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum     <= {s_bit, res_sh[WIDTH-1:1]};
                        co      <= c_nxt;
                        done_id <= sel_id;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fa_share_ctrl.sv
// tb/tb_fa_share_ctrl.sv - randomized self-checking bench for fa_share_ctrl
module tb_fa_share_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, co, done, done_id;
    logic [W-1:0] sum;

    int checks = 0;
    int failures = 0;
    int last_served = 1;

    typedef struct {
        int         id;
        logic [W:0] r;
    } exp_t;

    fa_share_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .sum(sum), .co(co), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step(); step();
        rst = 1'b0;
        last_served = 1;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 3 * W; i++) begin
            step();
            if (done) begin n = i; break; end
        end
    endtask

    task automatic run_add(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [W:0] expv;
        int n;
        expv = {1'b0, a} + {1'b0, b};
        if (id == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
        else         begin a1 = a; b1 = b; req1 = 1'b1; end
        step();
        checks++;
        if (gnt0 !== (id == 0) || gnt1 !== (id == 1) || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_gnt gnt0=%0b gnt1=%0b busy=%0b expected id=%0d", name, gnt0, gnt1, busy, id);
        end
        last_served = id;
        req0 = 1'b0; req1 = 1'b0;
        wait_done(n);
        checks++;
        if (n != W) begin
            failures++;
            $display("FAIL %s_latency got=%0d expected=%0d", name, n, W);
        end
        checks++;
        if ({co, sum} !== expv || done_id !== id[0]) begin
            failures++;
            $display("FAIL %s_result co=%0b sum=%h id=%0b expected co=%0b sum=%h id=%0d",
                     name, co, sum, done_id, expv[W], expv[W-1:0], id);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle done=%0b busy=%0b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req1 = 1'b0; req0 = 1'b1; a0 = 8'h21; b0 = 8'h43;
        a1 = '0; b1 = '0;
        #1;
        checks++;
        if ({gnt0, gnt1, busy, done, co, done_id} !== 6'b0 || sum !== '0) begin
            failures++;
            $display("FAIL reset_values gnt0=%0b gnt1=%0b busy=%0b done=%0b co=%0b id=%0b sum=%h expected all 0",
                     gnt0, gnt1, busy, done, co, done_id, sum);
        end
        step();
        checks++;
        if (gnt0 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold gnt0=%0b busy=%0b expected 0 0", gnt0, busy);
        end
        rst = 1'b0;
        last_served = 1;
        run_add(0, 8'h21, 8'h43, "reset_release");
    endtask

    task automatic test_single();
        run_add(0, 8'h3C, 8'h5A, "single");
    endtask

    task automatic test_overflow();
        run_add(1, 8'hFF, 8'h01, "wrap");
        run_add(1, 8'hFF, 8'hFF, "ffff");
    endtask

    task automatic test_contention();
        int         gi;
        bit         seen;
        logic [W:0] dres;
        logic       did;
        int         n;
        do_reset();
        a0 = 8'h10; b0 = 8'h20; a1 = 8'h7F; b1 = 8'h01;
        req0 = 1'b1; req1 = 1'b1;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL contend_first gnt0=%0b gnt1=%0b expected 1 0", gnt0, gnt1);
        end
        req0 = 1'b0;
        gi = -1; seen = 0; dres = '0; did = 1'b0;
        for (int i = 1; i <= 3 * W; i++) begin
            step();
            if (done) begin seen = 1; dres = {co, sum}; did = done_id; end
            if (gnt1) begin gi = i; break; end
        end
        checks++;
        if (gi != W + 2) begin
            failures++;
            $display("FAIL contend_spacing got=%0d expected=%0d", gi, W + 2);
        end
        checks++;
        if (!seen || dres !== 9'h030 || did !== 1'b0) begin
            failures++;
            $display("FAIL contend_res0 seen=%0b res=%h id=%0b expected res=030 id=0", seen, dres, did);
        end
        req1 = 1'b0;
        last_served = 1;
        wait_done(n);
        checks++;
        if (n != W || {co, sum} !== 9'h080 || done_id !== 1'b1) begin
            failures++;
            $display("FAIL contend_res1 lat=%0d res=%h id=%0b expected lat=%0d res=080 id=1", n, {co, sum}, done_id, W);
        end
        step();
    endtask

    task automatic test_fairness();
        exp_t q[$];
        exp_t e;
        int   grants = 0;
        int   low_run = 0;
        int   dones = 0;
        int   want;
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        for (int cyc = 0; cyc < 10 * (W + 2); cyc++) begin
            step();
            if (gnt0 || gnt1) begin
                want = 1 - last_served;
                checks++;
                if ((gnt0 && gnt1) || gnt1 !== want[0]) begin
                    failures++;
                    $display("FAIL fair_grant gnt0=%0b gnt1=%0b expected id=%0d", gnt0, gnt1, want);
                end
                e.id = want;
                e.r  = (want == 0) ? ({1'b0, a0} + {1'b0, b0}) : ({1'b0, a1} + {1'b0, b1});
                q.push_back(e);
                if (want == 0) begin a0 = W'($urandom); b0 = W'($urandom); end
                else           begin a1 = W'($urandom); b1 = W'($urandom); end
                last_served = want;
                grants++;
                if (grants == 6) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (done) begin
                dones++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    checks++;
                    if ({co, sum} !== e.r || done_id !== e.id[0]) begin
                        failures++;
                        $display("FAIL fair_result res=%h id=%0b expected res=%h id=%0d", {co, sum}, done_id, e.r, e.id);
                    end
                end
            end
            low_run = busy ? 0 : low_run + 1;
            if (grants < 6 && !busy) begin
                checks++;
                if (low_run > 1) begin
                    failures++;
                    $display("FAIL fair_busy idle_run=%0d expected<=1", low_run);
                end
            end
            if (grants == 6 && dones == 6) break;
        end
        checks++;
        if (grants != 6 || dones != 6 || q.size() != 0) begin
            failures++;
            $display("FAIL fair_count grants=%0d dones=%0d pending=%0d expected 6 6 0", grants, dones, q.size());
        end
        step(); step();
    endtask

    task automatic test_reset_midop();
        a0 = 8'hAA; b0 = 8'h55; req0 = 1'b1;
        step();
        req0 = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, busy, done, co, done_id} !== 6'b0 || sum !== '0) begin
            failures++;
            $display("FAIL midop_clear gnt0=%0b gnt1=%0b busy=%0b done=%0b co=%0b id=%0b sum=%h expected all 0",
                     gnt0, gnt1, busy, done, co, done_id, sum);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midop_nodone done=%0b busy=%0b expected 0 0", done, busy);
        end
        rst = 1'b0;
        last_served = 1;
        run_add(0, 8'hAA, 8'h55, "midop_retry");
    endtask

    task automatic test_operand_hold();
        int n;
        a0 = 8'h12; b0 = 8'h34; req0 = 1'b1;
        step();
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL hold_gnt gnt0=%0b expected 1", gnt0);
        end
        req0 = 1'b0;
        step(); step();
        a0 = 8'h00; b0 = 8'hFF;
        wait_done(n);
        checks++;
        if (n != W - 2 || {co, sum} !== 9'h046) begin
            failures++;
            $display("FAIL hold_result lat=%0d res=%h expected lat=%0d res=046", n, {co, sum}, W - 2);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (sum !== 8'h46 || co !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable sum=%h co=%0b done=%0b expected 46 0 0", sum, co, done);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            run_add(int'($urandom_range(0, 1)), W'($urandom), W'($urandom), "random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_contention();
        test_fairness();
        test_reset_midop();
        test_operand_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
